// File: rtl/conv_window_feeder.sv
// Front end of the 3x3 convolver: turns a serial kernel+raster stream into
// 3-pixel vertical columns, using two line buffers for the previous image rows.
module conv_window_feeder #(
  parameter int BIT_LEN    = 8,
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic               i_CLK,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [BIT_LEN-1:0] i_pixel,
  input  logic               i_pix_valid,
  output logic               o_pix_ready,
  output logic [BIT_LEN-1:0] o_dato0,
  output logic [BIT_LEN-1:0] o_dato1,
  output logic [BIT_LEN-1:0] o_dato2,
  output logic               o_selecK_I,
  output logic               o_valid,
  output logic               o_win_valid,
  output logic               o_busy,
  output logic               o_done
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, LOAD_K, FILL, STREAM} state_t;

  state_t             state;
  logic [3:0]         k_cnt;
  logic [XW-1:0]      x_cnt;
  logic [YW-1:0]      y_cnt;
  logic [BIT_LEN-1:0] k_row0;
  logic [BIT_LEN-1:0] k_row1;
  logic [BIT_LEN-1:0] lb0 [IMG_WIDTH];
  logic [BIT_LEN-1:0] lb1 [IMG_WIDTH];
  logic               xfer;
  logic               lb_shift;

  // o_pix_ready is high exactly when not IDLE, so it doubles as the accept gate.
  assign xfer     = i_pix_valid && o_pix_ready;
  assign lb_shift = xfer && (state == FILL || state == STREAM);

  // NOTE: line buffers carry no reset so they map onto RAM; FILL rewrites every
  // entry before STREAM reads it, so stale contents after reset are harmless.
  always_ff @(posedge i_CLK) begin
    if (lb_shift) begin
      lb0[x_cnt] <= lb1[x_cnt];
      lb1[x_cnt] <= i_pixel;
    end
  end

  // NOTE: all state uses non-blocking assignments, so the STREAM reads of
  // lb0/lb1 below see the pre-shift contents even when the address matches.
  always_ff @(posedge i_CLK or posedge i_reset) begin
    if (i_reset) begin
      state       <= IDLE;
      k_cnt       <= '0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      k_row0      <= '0;
      k_row1      <= '0;
      o_pix_ready <= 1'b0;
      o_dato0     <= '0;
      o_dato1     <= '0;
      o_dato2     <= '0;
      o_selecK_I  <= 1'b0;
      o_valid     <= 1'b0;
      o_win_valid <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      o_valid     <= 1'b0;
      o_win_valid <= 1'b0;
      o_done      <= 1'b0;

      case (state)
        IDLE: begin
          if (i_start) begin
            state       <= LOAD_K;
            k_cnt       <= '0;
            x_cnt       <= '0;
            y_cnt       <= '0;
            o_pix_ready <= 1'b1;
            o_busy      <= 1'b1;
          end
        end

        LOAD_K: begin
          if (xfer) begin
            // Coefficients arrive column-major; rows 0 and 1 wait for row 2.
            case (k_cnt)
              4'd0, 4'd3, 4'd6: k_row0 <= i_pixel;
              4'd1, 4'd4, 4'd7: k_row1 <= i_pixel;
              default: begin
                o_valid    <= 1'b1;
                o_selecK_I <= 1'b0;
                o_dato0    <= k_row0;
                o_dato1    <= k_row1;
                o_dato2    <= i_pixel;
              end
            endcase
            if (k_cnt == 4'd8) begin
              state <= FILL;
            end else begin
              k_cnt <= k_cnt + 4'd1;
            end
          end
        end

        FILL: begin
          if (xfer) begin
            if (x_cnt == X_LAST) begin
              x_cnt <= '0;
              y_cnt <= y_cnt + 1'b1;
              if (y_cnt == YW'(1)) state <= STREAM;
            end else begin
              x_cnt <= x_cnt + 1'b1;
            end
          end
        end

        STREAM: begin
          if (xfer) begin
            o_valid     <= 1'b1;
            o_selecK_I  <= 1'b1;
            o_dato0     <= lb0[x_cnt];
            o_dato1     <= lb1[x_cnt];
            o_dato2     <= i_pixel;
            o_win_valid <= (x_cnt >= XW'(2));
            if (x_cnt == X_LAST) begin
              x_cnt <= '0;
              if (y_cnt == Y_LAST) begin
                o_done      <= 1'b1;
                o_pix_ready <= 1'b0;
                o_busy      <= 1'b0;
                state       <= IDLE;
              end else begin
                y_cnt <= y_cnt + 1'b1;
              end
            end else begin
              x_cnt <= x_cnt + 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_feeder.sv
// Self-checking bench for conv_window_feeder: a transfer-indexed reference model
// predicts every column from the kernel/image arrays.
module tb_conv_window_feeder;

  localparam int BL = 8;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int NK = 9;
  localparam int NT = NK + W * H;

  logic          i_CLK;
  logic          i_reset;
  logic          i_start;
  logic [BL-1:0] i_pixel;
  logic          i_pix_valid;
  logic          o_pix_ready;
  logic [BL-1:0] o_dato0, o_dato1, o_dato2;
  logic          o_selecK_I, o_valid, o_win_valid, o_busy, o_done;

  conv_window_feeder #(.BIT_LEN(BL), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .i_CLK      (i_CLK),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_pixel    (i_pixel),
    .i_pix_valid(i_pix_valid),
    .o_pix_ready(o_pix_ready),
    .o_dato0    (o_dato0),
    .o_dato1    (o_dato1),
    .o_dato2    (o_dato2),
    .o_selecK_I (o_selecK_I),
    .o_valid    (o_valid),
    .o_win_valid(o_win_valid),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  initial i_CLK = 1'b0;
  always #5 i_CLK = ~i_CLK;

  int n_checks = 0;
  int n_fail   = 0;

  logic [BL-1:0] kern [NK];
  logic [BL-1:0] img  [H][W];
  logic [BL-1:0] last0, last1, last2;
  logic          last_sel;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [BL-1:0] pix_of(input int t);
    if (t < NK) return kern[t];
    return img[(t - NK) / W][(t - NK) % W];
  endfunction

  // Expected outputs one cycle after transfer number pt (pt < 0: no transfer).
  task automatic check_outputs(input int pt);
    logic          ev, ed, ew, es;
    logic [BL-1:0] e0, e1, e2;
    int p, x, y;
    ev = 1'b0; ed = 1'b0; ew = 1'b0;
    es = last_sel; e0 = last0; e1 = last1; e2 = last2;
    if (pt >= 0 && pt < NK) begin
      if (pt % 3 == 2) begin
        ev = 1'b1; es = 1'b0;
        e0 = kern[pt-2]; e1 = kern[pt-1]; e2 = kern[pt];
      end
    end else if (pt >= NK) begin
      p = pt - NK; y = p / W; x = p % W;
      if (y >= 2) begin
        ev = 1'b1; es = 1'b1;
        e0 = img[y-2][x]; e1 = img[y-1][x]; e2 = img[y][x];
        ew = (x >= 2);
        ed = (pt == NT - 1);
      end
    end
    check("o_valid",     32'(o_valid),     32'(ev));
    check("o_win_valid", 32'(o_win_valid), 32'(ew));
    check("o_done",      32'(o_done),      32'(ed));
    check("o_selecK_I",  32'(o_selecK_I),  32'(es));
    check("o_dato0",     32'(o_dato0),     32'(e0));
    check("o_dato1",     32'(o_dato1),     32'(e1));
    check("o_dato2",     32'(o_dato2),     32'(e2));
    last0 = e0; last1 = e1; last2 = e2; last_sel = es;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(o_pix_ready), 32'(0));
    check({tag, "_valid"}, 32'(o_valid),     32'(0));
    check({tag, "_win"},   32'(o_win_valid), 32'(0));
    check({tag, "_busy"},  32'(o_busy),      32'(0));
    check({tag, "_done"},  32'(o_done),      32'(0));
    check({tag, "_sel"},   32'(o_selecK_I),  32'(0));
    check({tag, "_d0"},    32'(o_dato0),     32'(0));
    check({tag, "_d1"},    32'(o_dato1),     32'(0));
    check({tag, "_d2"},    32'(o_dato2),     32'(0));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge i_CLK);
      check_outputs(-1);
      check("idle_busy",  32'(o_busy),      32'(0));
      check("idle_ready", 32'(o_pix_ready), 32'(0));
      i_start     = 1'b0;
      i_pix_valid = 1'(i % 2);
      i_pixel     = 8'($urandom);
    end
    i_pix_valid = 1'b0;
  endtask

  // Asynchronous reset applied mid-cycle (called right after a falling edge).
  task automatic mid_cycle_reset();
    #2 i_reset = 1'b1;
    #1 check_all_zero("reset_async");
    i_pix_valid = 1'b0;
    i_start     = 1'b0;
    @(negedge i_CLK);
    i_reset = 1'b0;
    last0 = '0; last1 = '0; last2 = '0; last_sel = 1'b0;
  endtask

  // gap_mode: 0 back-to-back, 1 toggling, 2 random. abort_t >= 0 resets before that transfer.
  task automatic run_seq(input int gap_mode, input bit busy_start, input int abort_t);
    int t, pt, cycles;
    logic v;
    @(negedge i_CLK);
    i_start = 1'b1; i_pix_valid = 1'b0;
    t = 0; pt = -1; cycles = 0;
    while (t < NT) begin
      @(negedge i_CLK);
      cycles++;
      check_outputs(pt);
      check("seq_busy",  32'(o_busy),      32'(1));
      check("seq_ready", 32'(o_pix_ready), 32'(1));
      if (abort_t >= 0 && t == abort_t) begin
        mid_cycle_reset();
        idle_cycles(3);
        return;
      end
      if (cycles > 8 * NT) begin
        n_checks++; n_fail++;
        $display("FAIL cycle_budget: got %0d transfers expected %0d", t, NT);
        break;
      end
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = 1'(cycles % 2);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      i_start = 1'b0;
      if (busy_start && (t == NK + 2 * W + 1 || t == NT - 1)) i_start = 1'b1;
      i_pix_valid = v;
      i_pixel     = v ? pix_of(t) : 8'($urandom);
      if (v && o_pix_ready) begin
        pt = t; t++;
      end else begin
        pt = -1;
      end
    end
    @(negedge i_CLK);
    check_outputs(pt);
    check("end_busy",  32'(o_busy),      32'(0));
    check("end_ready", 32'(o_pix_ready), 32'(0));
    i_pix_valid = 1'b0; i_start = 1'b0;
    idle_cycles(3);
  endtask

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_pix_valid = 1'b0; i_pixel = '0;
    last0 = '0; last1 = '0; last2 = '0; last_sel = 1'b0;
    #3 check_all_zero("reset");
    @(negedge i_CLK);
    i_reset = 1'b0;

    idle_cycles(4);

    for (int i = 0; i < NK; i++) kern[i] = 8'(i + 1);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y][x] = 8'(10 * y + x);

    run_seq(0, 1'b0, -1);
    run_seq(1, 1'b0, -1);
    run_seq(0, 1'b1, -1);
    run_seq(0, 1'b0, NK + 2 * W + 1);
    run_seq(0, 1'b0, -1);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NK; i++) kern[i] = 8'($urandom);
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++) img[y][x] = 8'($urandom);
      run_seq(2, 1'(r % 2), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
